// File: rtl/sync_ram_dp_be.sv
// Single-clock simple-dual-port RAM with per-byte write enables, 1- or 2-cycle
// read latency, selectable read-during-write behaviour and an optional clear sweep.
module sync_ram_dp_be #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy
);

    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    // Handshake: a request is accepted on a rising edge where the FSM is IDLE,
    // rst_n=1, cs=1 and rd/wr=1; there is no backpressure, rd_valid pulses for
    // exactly one cycle RD_LAT edges after the accepting edge.
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              wr_in, rd_in;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign idle  = (state_q == ST_IDLE);
    assign wr_in = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_ok = rst_n && idle && cs && wr && wr_in;
    assign rd_ok = rst_n && idle && cs && rd;

    always_ff @(posedge clk) begin
        if (rst_n && clr_we) begin
            mem[ptr_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Array read returns pre-write contents; write-first mode overlays enabled lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_addr];
            if ((RDW_MODE != 0) && wr_ok && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) s1_data <= rd_word;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= s1_valid;
                    if (s1_valid) rd_data <= s1_data;
                end
            end
        end else begin : g_lat1
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ram_dp_be.sv
// Directed bench for sync_ram_dp_be: three instances (read-first, write-first,
// two-cycle latency) share one stimulus stream; each has its own expected queue.
module tb_sync_ram_dp_be;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int D  = 12;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cs      = 1'b0;
    logic          wr      = 1'b0;
    logic          rd      = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be   = '0;

    logic [DW-1:0] rd_data0, rd_data1, rd_data2;
    logic          rd_valid0, rd_valid1, rd_valid2;
    logic          busy0, busy1, busy2;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    logic [DW-1:0] final_mem [D];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sync_ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
    );
    sync_ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(1), .RDW_MODE(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
    );
    sync_ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected response for instance inst, due RD_LAT edges after the next edge's acceptance.
    task automatic push(input int inst, input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = 32'(edge_cnt + ((inst == 2) ? 2 : 1));
        case (inst)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int inst, input logic v, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        if (v === 1'b0) return;
        n = (inst == 0) ? exp_q0.size() : (inst == 1) ? exp_q1.size() : exp_q2.size();
        if (n == 0) begin
            check($sformatf("u%0d rd_valid with no read pending", inst), 32'(v), 32'd0);
            return;
        end
        case (inst)
            0:       e = exp_q0.pop_front();
            1:       e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
        endcase
        check($sformatf("u%0d rd_data", inst), 32'(d), 32'(e.data));
        check($sformatf("u%0d rd_valid edge", inst), 32'(edge_cnt), e.due);
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, rd_valid0, rd_data0);
        mon(1, rd_valid1, rd_data1);
        mon(2, rd_valid2, rd_data2);
    end

    task automatic drive(input logic c, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [1:0] be, input logic r, input logic [AW-1:0] ra);
        @(negedge clk);
        cs = c; wr = w; wr_addr = wa; wr_data = wd; wr_be = be; rd = r; rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        drive(1'b1, 1'b1, a, d, be, 1'b0, '0);
    endtask

    task automatic rd_op(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [2:0] m);
        drive(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, a);
        if (m[0]) push(0, e0);
        if (m[1]) push(1, e1);
        if (m[2]) push(2, e2);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " u0 rd_data"}, 32'(rd_data0), 32'd0);
        check({tag, " u1 rd_data"}, 32'(rd_data1), 32'd0);
        check({tag, " u2 rd_data"}, 32'(rd_data2), 32'd0);
        check({tag, " u0 rd_valid"}, 32'(rd_valid0), 32'd0);
        check({tag, " u2 rd_valid"}, 32'(rd_valid2), 32'd0);
        check({tag, " u0 busy"}, 32'(busy0), 32'd1);
        check({tag, " u2 busy"}, 32'(busy2), 32'd1);
    endtask

    // Called on the negedge where rst_n was just released; optionally hammers requests while busy.
    task automatic count_busy(input logic req);
        int n0, n1, n2;
        n0 = 0; n1 = 0; n2 = 0;
        for (int k = 0; k < 64; k++) begin
            if (busy0 !== 1'b1 && busy1 !== 1'b1 && busy2 !== 1'b1) break;
            if (busy0 === 1'b1) n0++;
            if (busy1 === 1'b1) n1++;
            if (busy2 === 1'b1) n2++;
            if (req) begin
                cs = 1'b1; wr = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF; wr_be = 2'b11;
                rd = 1'b1; rd_addr = 4'd3;
            end
            @(negedge clk);
        end
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        check("u0 busy cycles", 32'(n0), 32'd12);
        check("u1 busy cycles", 32'(n1), 32'd12);
        check("u2 busy cycles", 32'(n2), 32'd12);
    endtask

    initial begin
        final_mem[0] = 16'h0010; final_mem[1]  = 16'h0011; final_mem[2]  = 16'h0012; final_mem[3]  = 16'h12CD;
        final_mem[4] = 16'h0000; final_mem[5]  = 16'h0000; final_mem[6]  = 16'h0000; final_mem[7]  = 16'h5534;
        final_mem[8] = 16'h0000; final_mem[9]  = 16'h0000; final_mem[10] = 16'h0000; final_mem[11] = 16'h0000;

        repeat (2) @(negedge clk);
        check_reset_state("power-up");
        rst_n = 1'b1;
        count_busy(1'b0);

        // Preload, then reset while u2's copy of the read is still in flight.
        wr_op(4'd5, 16'hBEEF, 2'b11);
        rd_op(4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'b011);
        reset_pulse();
        check_reset_state("reset after read");
        count_busy(1'b0);
        rd_op(4'd5, 16'h0000, 16'h0000, 16'h0000, 3'b111);

        wr_op(4'd3, 16'h1234, 2'b11);
        wr_op(4'd3, 16'hABCD, 2'b01);
        rd_op(4'd3, 16'h12CD, 16'h12CD, 16'h12CD, 3'b111);

        wr_op(4'd7, 16'h00AA, 2'b11);
        drive(1'b1, 1'b1, 4'd7, 16'h5555, 2'b11, 1'b1, 4'd7);
        push(0, 16'h00AA); push(1, 16'h5555); push(2, 16'h00AA);
        rd_op(4'd7, 16'h5555, 16'h5555, 16'h5555, 3'b111);
        drive(1'b1, 1'b1, 4'd7, 16'h1234, 2'b01, 1'b1, 4'd7);
        push(0, 16'h5555); push(1, 16'h5534); push(2, 16'h5555);

        wr_op(4'd0, 16'h0010, 2'b11);
        wr_op(4'd1, 16'h0011, 2'b11);
        wr_op(4'd2, 16'h0012, 2'b11);
        rd_op(4'd0, 16'h0010, 16'h0010, 16'h0010, 3'b111);
        rd_op(4'd1, 16'h0011, 16'h0011, 16'h0011, 3'b111);
        rd_op(4'd2, 16'h0012, 16'h0012, 16'h0012, 3'b111);
        idle();
        repeat (4) @(negedge clk);
        check("u0 rd_data hold", 32'(rd_data0), 32'h0012);
        check("u1 rd_data hold", 32'(rd_data1), 32'h0012);
        check("u2 rd_data hold", 32'(rd_data2), 32'h0012);

        wr_op(4'd13, 16'hFFFF, 2'b11);
        drive(1'b0, 1'b1, 4'd4, 16'hFFFF, 2'b11, 1'b1, 4'd4);
        rd_op(4'd13, 16'h0000, 16'h0000, 16'h0000, 3'b111);
        for (int i = 0; i < D; i++) begin
            rd_op(AW'(i), final_mem[i], final_mem[i], final_mem[i], 3'b111);
        end
        idle();
        repeat (4) @(negedge clk);

        // Reset part-way through a sweep, then hit the busy RAM with requests.
        reset_pulse();
        repeat (6) @(negedge clk);
        reset_pulse();
        count_busy(1'b1);
        for (int i = 0; i < D; i++) begin
            rd_op(AW'(i), 16'h0000, 16'h0000, 16'h0000, 3'b111);
        end
        idle();
        repeat (6) @(negedge clk);

        check("u0 reads outstanding", 32'(exp_q0.size()), 32'd0);
        check("u1 reads outstanding", 32'(exp_q1.size()), 32'd0);
        check("u2 reads outstanding", 32'(exp_q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ram_dp_be.md
Name: sync_ram_dp_be

Overview:
Parametrised single-clock simple-dual-port synchronous RAM, successor to the team's 1K x 8 single-port chip-select RAM.
- Separate write and read ports; a read and a write may complete in the same cycle.
- Per-byte write enables.
- Selectable read latency and read-during-write behaviour.
- Optional hardware clear-on-reset sequencer with a busy flag.
- Used as generic scratch/buffer memory behind bus slaves and datapath blocks.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8.
ADDR_W, 10, address width in bits.
DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
RDW_MODE, 0, same-address read during write: 0 = old data (read-first), 1 = new data (write-first).
CLEAR_ON_RST, 1, 1 = sweep memory to zero after reset; 0 = contents undefined after power-up and untouched by reset.

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
cs  input  1  chip select; qualifies rd and wr
wr  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data
rd_valid  output  1  one-cycle pulse marking rd_data valid for an accepted read
busy  output  1  high while the clear sweep runs; requests are ignored

Behaviour:
- Reset: when rst_n is low at a rising edge:
  - rd_data=0 and rd_valid=0; the read pipeline is flushed and in-flight reads are dropped.
  - Clear pointer=0. State=CLEAR if CLEAR_ON_RST=1, else IDLE.
  - busy=1 on the first cycle after reset if CLEAR_ON_RST=1, else 0.
  - Memory array is not reset directly.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. After writing ptr==DEPTH-1, go to IDLE. The sweep takes exactly DEPTH cycles after the reset release edge.
  - busy=1 throughout CLEAR; busy=0 in IDLE.
  - cs, rd and wr are ignored in CLEAR; rd_valid stays 0.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Write (IDLE): at an edge with cs=1, wr=1, wr_addr<DEPTH, each byte lane i with wr_be[i]=1 is updated; other lanes keep their value.
  - wr_be=0 performs no write.
  - wr_addr>=DEPTH: write is dropped silently.
- Read (IDLE): accepted at an edge with cs=1, rd=1.
  - rd_data is updated and rd_valid pulses high RD_LAT cycles after the accepting edge (RD_LAT=1: visible after that same edge; RD_LAT=2: one register stage later).
  - Fully pipelined: one read accepted per cycle; back-to-back reads give consecutive rd_valid pulses.
  - rd_addr>=DEPTH: returns all-zero data with rd_valid=1.
  - rd_data holds its last value when no read completes.
- cs=0: no read and no write, regardless of rd and wr.
- Simultaneous read and write (IDLE, cs=1, rd=1, wr=1): both are performed.
  - Different addresses: independent.
  - Same address, RDW_MODE=0: read returns pre-write contents.
  - Same address, RDW_MODE=1: read returns the merged result (enabled lanes from wr_data, other lanes old contents).
- In-flight reads completing in the cycle reset is released are discarded; rd_valid is 0 for the whole of CLEAR.

Test Plan:
Bench config: DATA_W=16, ADDR_W=4, DEPTH=12, RD_LAT=1, RDW_MODE=0, CLEAR_ON_RST=1 unless stated.
- Clear: pre-load mem[5]=16'hBEEF, pulse rst_n low 1 cycle -> busy=1 for exactly 12 cycles then 0; read addr 5 -> rd_data=16'h0000, rd_valid pulse 1 cycle later.
- Byte enables: write addr 3 data 16'h1234 be=2'b11, then data 16'hABCD be=2'b01 -> read addr 3 returns 16'h12CD.
- Read-during-write:
  - RDW_MODE=0: mem[7]=16'h00AA; same edge write 16'h5555 be=11 and read addr 7 -> rd_data=16'h00AA; next read -> 16'h5555.
  - Rerun with RDW_MODE=1 -> first read returns 16'h5555.
- Pipelining with RD_LAT=2: reads to addrs 0,1,2 on consecutive cycles after writing 16'h0010/0011/0012 -> rd_valid high 3 consecutive cycles starting 2 cycles after the first request, with data in order.
- Boundaries:
  - Write addr 13 (>=DEPTH) data 16'hFFFF -> no memory change.
  - Read addr 13 -> rd_data=0, rd_valid=1.
  - cs=0 with rd=wr=1 -> no rd_valid, no write.
- Reset mid-sweep: assert rst_n low at sweep cycle 6 -> busy stays 1 for a fresh 12 cycles after release; requests during busy -> no rd_valid, memory unchanged.
